// File: rtl/coeff_stream_reader.sv
// -----------------------------------------------------------------------------
// coeff_stream_reader
//
// Walks a flat, packed bus of N complex twiddle coefficients and presents one
// coefficient per accepted transfer on a valid/ready stream. The walk can be
// repeated for several passes. For inverse transforms the imaginary part can
// be conjugated, with saturation.
//
// Bus layout: slot k = coeff_data[2*NBITS*(k+1)-1 : 2*NBITS*k], where
// re = upper NBITS bits and im = lower NBITS bits. Index i reads slot N-1-i,
// so the MSB slot is emitted first.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   coeff_data  packed coefficient bus (held static while busy)
//   start       one-cycle request, honoured only in IDLE
//   conj        sampled at start; 1 = negate imaginary part (saturating)
//   num_passes  sampled at start; 0 is treated as 1
//   abort       synchronous cancel back to IDLE, no done
//   out_valid   coefficient present
//   out_ready   downstream accepts
//   out_re      real component
//   out_im      imaginary component (conjugated if requested)
//   out_idx     coefficient index within the pass
//   out_last    out_idx == N-1
//   busy        high while streaming (equal to out_valid)
//   done        one-cycle pulse after the final transfer
// -----------------------------------------------------------------------------
module coeff_stream_reader #(
  parameter  int NBITS = 11,
  parameter  int N     = 32,
  parameter  int PW    = 4,
  localparam int IDXW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NBITS*N*2-1:0]    coeff_data,
  input  logic                    start,
  input  logic                    conj,
  input  logic [PW-1:0]           num_passes,
  input  logic                    abort,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NBITS-1:0]        out_re,
  output logic [NBITS-1:0]        out_im,
  output logic [IDXW-1:0]         out_idx,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(N - 1);
  localparam logic [NBITS-1:0] IM_MIN   = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [NBITS-1:0] IM_MAX   = {1'b0, {(NBITS-1){1'b1}}};

  state_t            r_state;
  logic [IDXW-1:0]   r_idx;
  logic [PW-1:0]     r_pass;
  logic [PW-1:0]     r_passes;
  logic              r_conj;
  logic              r_out_valid;
  logic [NBITS-1:0]  r_out_re;
  logic [NBITS-1:0]  r_out_im;
  logic              r_out_last;
  logic              r_busy;
  logic              r_done;

  // Index and conjugate mode of the coefficient that the next load edge
  // (entry into RUN or a handshake) will place on the outputs.
  logic [IDXW-1:0]   w_load_idx;
  logic              w_load_conj;
  logic [IDXW-1:0]   w_slot;
  int                w_base;
  logic [NBITS-1:0]  w_re_raw;
  logic [NBITS-1:0]  w_im_raw;
  logic [NBITS-1:0]  w_im;
  logic              w_handshake;
  logic              w_final_pass;

  // NOTE: every signal written in an always_comb gets a default assignment
  // first; a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_load_idx  = '0;
    w_load_conj = r_conj;
    if (r_state == S_IDLE) begin
      // Entry into RUN: index 0 with the conj value being latched this edge.
      w_load_conj = conj;
    end else if (r_idx != LAST_IDX) begin
      w_load_idx = r_idx + IDXW'(1);
    end
  end

  assign w_slot   = LAST_IDX - w_load_idx;
  assign w_base   = 2 * NBITS * int'(w_slot);
  assign w_re_raw = coeff_data[w_base + NBITS +: NBITS];
  assign w_im_raw = coeff_data[w_base +: NBITS];

  // Negating the most negative value would overflow back to itself, so it
  // saturates to the largest positive value instead.
  always_comb begin
    w_im = w_im_raw;
    if (w_load_conj) begin
      if (w_im_raw == IM_MIN) w_im = IM_MAX;
      else                    w_im = ~w_im_raw + NBITS'(1);
    end
  end

  assign w_handshake  = r_out_valid && out_ready;
  assign w_final_pass = (r_pass == r_passes - PW'(1));

  // NOTE: all state in this block uses non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_pass      <= '0;
      r_passes    <= '0;
      r_conj      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_conj      <= conj;
            r_passes    <= (num_passes == '0) ? PW'(1) : num_passes;
            r_pass      <= '0;
            r_idx       <= w_load_idx;
            r_out_re    <= w_re_raw;
            r_out_im    <= w_im;
            r_out_last  <= (w_load_idx == LAST_IDX);
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end

        S_RUN: begin
          // abort outranks a handshake in the same cycle.
          if (abort) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end else if (w_handshake) begin
            if (r_idx == LAST_IDX && w_final_pass) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              // Covers both the in-pass step and the wrap to index 0, so the
              // pass boundary costs no bubble.
              if (r_idx == LAST_IDX) r_pass <= r_pass + PW'(1);
              r_idx      <= w_load_idx;
              r_out_re   <= w_re_raw;
              r_out_im   <= w_im;
              r_out_last <= (w_load_idx == LAST_IDX);
            end
          end
        end

        S_DONE: begin
          // done is cleared by the default above; abort lands in the same
          // place, so it needs no separate branch here.
          r_state <= S_IDLE;
        end

        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_re    = r_out_re;
  assign out_im    = r_out_im;
  assign out_idx   = r_idx;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_coeff_stream_reader.sv
// -----------------------------------------------------------------------------
// Testbench for coeff_stream_reader. Expected beats are pushed to a queue when
// a run is started and are compared and popped by a monitor as the DUT
// presents and transfers them.
// -----------------------------------------------------------------------------
module tb_coeff_stream_reader;

  localparam int NBITS = 11;
  localparam int N     = 32;
  localparam int PW    = 4;
  localparam int IDXW  = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NBITS*N*2-1:0] coeff_data;
  logic                 start;
  logic                 conj;
  logic [PW-1:0]        num_passes;
  logic                 abort;
  logic                 out_valid;
  logic                 out_ready;
  logic [NBITS-1:0]     out_re;
  logic [NBITS-1:0]     out_im;
  logic [IDXW-1:0]      out_idx;
  logic                 out_last;
  logic                 busy;
  logic                 done;

  always #5 clk = ~clk;

  coeff_stream_reader #(.NBITS(NBITS), .N(N), .PW(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .coeff_data (coeff_data),
    .start      (start),
    .conj       (conj),
    .num_passes (num_passes),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_re     (out_re),
    .out_im     (out_im),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [IDXW-1:0]  idx;
    logic [NBITS-1:0] re;
    logic [NBITS-1:0] im;
    logic             last;
  } beat_t;

  beat_t sb[$];

  int n_vec    = 0;
  int n_miss   = 0;
  int cyc      = 0;
  int hs_cnt   = 0;
  int last_cnt = 0;
  int hs_edge  = 0;
  bit bp_mode  = 1'b0;
  bit ready_lvl = 1'b1;

  logic signed [NBITS-1:0] rom_re [N];
  logic signed [NBITS-1:0] rom_im [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NBITS-1:0] model_im(input logic signed [NBITS-1:0] v, input logic c);
    int x;
    if (!c) return v;
    x = -int'(v);
    if (x > (1 << (NBITS-1)) - 1) x = (1 << (NBITS-1)) - 1;
    return NBITS'(x);
  endfunction

  task automatic pack_rom();
    for (int i = 0; i < N; i++) begin
      coeff_data[2*NBITS*(N-1-i) + NBITS +: NBITS] = rom_re[i];
      coeff_data[2*NBITS*(N-1-i) +: NBITS]         = rom_im[i];
    end
  endtask

  task automatic default_rom();
    for (int i = 0; i < N; i++) begin
      rom_re[i] = NBITS'(512 - 14 * i);
      rom_im[i] = NBITS'(-(16 * i) + 3);
    end
    rom_re[0]  = 11'sd512;  rom_im[0]  = 11'sd0;
    rom_re[9]  = 11'sd502;  rom_im[9]  = -11'sd100;
    rom_re[31] = 11'sd50;   rom_im[31] = -11'sd510;
    pack_rom();
  endtask

  always @(posedge clk) cyc++;

  // out_ready driver: a level, or the repeating 1,0,0 backpressure pattern.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) out_ready = (cyc % 3 == 0);
      else         out_ready = ready_lvl;
    end
  end

  // Monitor: sampled mid-cycle, so out_valid & out_ready here is the
  // handshake taken at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy_eq_valid", busy, out_valid);
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("extra_beat", out_valid, 1'b0);
        end else begin
          check($sformatf("beat_idx%0d", sb[0].idx),
                {out_idx, out_re, out_im, out_last},
                {sb[0].idx, sb[0].re, sb[0].im, sb[0].last});
          if (out_ready && !abort) begin
            void'(sb.pop_front());
            hs_cnt++;
            if (out_last) last_cnt++;
            hs_edge = cyc + 1;
          end
        end
      end
    end
  end

  task automatic begin_run(input logic conj_i, input logic [PW-1:0] np);
    int p;
    beat_t b;
    sb.delete();
    hs_cnt   = 0;
    last_cnt = 0;
    p = (np == 0) ? 1 : int'(np);
    for (int k = 0; k < p; k++) begin
      for (int i = 0; i < N; i++) begin
        b.idx  = IDXW'(i);
        b.re   = rom_re[i];
        b.im   = model_im(rom_im[i], conj_i);
        b.last = (i == N - 1);
        sb.push_back(b);
      end
    end
    conj       = conj_i;
    num_passes = np;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    conj       = ~conj_i;
    num_passes = PW'($urandom);
    check("start_latency", {out_valid, busy, out_idx}, {1'b1, 1'b1, 5'd0});
  endtask

  task automatic wait_done(input int exp_cnt, input int mid_start, input int np_eff);
    int cnt;
    cnt = 1;
    while (!done && cnt < 2000) begin
      if (mid_start > 0) start = (cnt == mid_start);
      @(posedge clk);
      #1;
      cnt++;
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
    if (done) begin
      if (exp_cnt > 0) check("done_cycle", cnt, exp_cnt);
      check("xfer_count", hs_cnt, N * np_eff);
      check("last_count", last_cnt, np_eff);
      check("sb_empty", sb.size(), 0);
      check("done_after_last_hs", cyc, hs_edge);
      check("done_state", {out_valid, busy}, 2'b00);
      // A start presented during DONE must be ignored.
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("done_one_cycle", done, 1'b0);
      check("start_in_done_ignored", out_valid, 1'b0);
    end
  endtask

  task automatic run(input logic conj_i, input logic [PW-1:0] np, input int exp_cnt, input int mid_start);
    begin_run(conj_i, np);
    wait_done(exp_cnt, mid_start, (np == 0) ? 1 : int'(np));
  endtask

  initial begin
    int cnt;
    rst        = 1'b1;
    start      = 1'b0;
    conj       = 1'b0;
    num_passes = '0;
    abort      = 1'b0;
    default_rom();
    #1;
    check("reset_outs", {out_valid, out_re, out_im, out_idx, out_last, busy, done}, '0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_reset", {out_valid, busy, done}, 3'b000);

    // Plain pass, then conjugated pass.
    run(1'b0, 4'd1, 33, 0);
    run(1'b1, 4'd1, 33, 0);

    // Saturation of the most negative imaginary value at index 0.
    rom_im[0] = -11'sd1024;
    pack_rom();
    run(1'b1, 4'd1, 33, 0);
    default_rom();

    // Backpressure with the 1,0,0 ready pattern.
    bp_mode = 1'b1;
    run(1'b0, 4'd1, 0, 0);
    bp_mode = 1'b0;

    // Pass-count handling: 0 means one pass; 3 passes wrap with no bubble.
    run(1'b0, 4'd0, 33, 0);
    run(1'b0, 4'd3, 97, 0);

    // start while running is ignored.
    run(1'b1, 4'd1, 33, 10);

    // Abort at index 10.
    begin_run(1'b0, 4'd1);
    cnt = 0;
    while (out_idx != 5'd10 && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("reach_idx10", out_idx, 5'd10);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_drop", {out_valid, busy, done}, 3'b000);
    sb.delete();
    repeat (3) begin
      @(posedge clk);
      #1;
      check("abort_no_done", {done, out_valid}, 2'b00);
    end
    run(1'b0, 4'd1, 33, 0);

    // Asynchronous reset at index 5.
    begin_run(1'b1, 4'd2);
    cnt = 0;
    while (out_idx != 5'd5 && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("reach_idx5", out_idx, 5'd5);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst", {out_valid, out_re, out_im, out_idx, out_last, busy, done}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_no_done", {done, out_valid}, 2'b00);
    end
    run(1'b0, 4'd1, 33, 0);

    // Random coefficients, including a saturating entry, two passes and
    // then a backpressured conjugated pass.
    for (int i = 0; i < N; i++) begin
      rom_re[i] = NBITS'($urandom);
      rom_im[i] = NBITS'($urandom);
    end
    rom_im[7] = -11'sd1024;
    pack_rom();
    run(1'b1, 4'd2, 65, 0);
    bp_mode = 1'b1;
    run(1'b1, 4'd1, 0, 0);
    bp_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/coeff_stream_reader.md
# coeff_stream_reader

Consumer-side sequencer for the packed twiddle-coefficient ROM bus (`coeff_data`, N complex entries of 2·NBITS bits). On a start request it walks the flat bus entry by entry and presents one complex coefficient per accepted transfer on a valid/ready stream into the butterfly datapath. It can repeat the walk for several passes and can optionally conjugate the coefficients for inverse transforms. It sits between the constant coefficient modules and the per-stage butterfly units.

## Interface
- NBITS, 11, width of each real/imag component (signed two's complement, 1.0 = 2^(NBITS-2))
- N, 32, number of complex coefficients on the bus
- PW, 4, width of the pass-count input
- clk  in  1  rising-edge clock
- rst  in  1  reset: one clock; reset is asynchronous and active-high
- coeff_data  in  NBITS*N*2  packed coefficients; static while busy
- start  in  1  one-cycle request, honoured only in IDLE
- conj  in  1  sampled at start; 1 = negate the imaginary part
- num_passes  in  PW  sampled at start; 0 treated as 1
- abort  in  1  synchronous cancel, returns to IDLE without done
- out_valid  out  1  coefficient present
- out_ready  in  1  downstream accepts
- out_re / out_im  out  NBITS each  coefficient components
- out_idx  out  clog2(N)  coefficient index within the pass
- out_last  out  1  out_idx == N-1
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the final transfer

## Operation
- Bus layout: slot k occupies bits [2·NBITS·(k+1)-1 : 2·NBITS·k]. Within a slot, the upper NBITS bits are re and the lower NBITS bits are im.
- Index i is read from slot N-1-i, so the MSB slot is emitted first.
- FSM states:
  - IDLE: on start, latch conj_r and passes_r (with 0 mapped to 1), set idx=0 and pass=0, go to RUN.
  - RUN: hold out_valid=1.
    - On a handshake (out_valid & out_ready) with idx<N-1: idx+1.
    - On a handshake at idx==N-1 with pass<passes_r-1: idx=0, pass+1.
    - On a handshake at idx==N-1 on the final pass: go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE unconditionally.
- abort in RUN or DONE: go to IDLE next edge, with no done and out_valid dropping next cycle. abort has priority over a simultaneous handshake.
- start while busy or in DONE is ignored.
- Conjugation: out_im = -im, saturating. -2^(NBITS-1) maps to 2^(NBITS-1)-1. out_re is never modified.
- Outputs are registered: out_re, out_im, out_idx and out_last are loaded from the selected slot on the entry edge and on each handshake edge.
- While out_valid & !out_ready, all out_* hold stable.
- Reset values: state=IDLE, out_valid=0, out_re=0, out_im=0, out_idx=0, out_last=0, busy=0, done=0, internal pass/idx/conj_r/passes_r=0.
- Async reset mid-RUN clears everything immediately. No done is produced.

## Timing
- start sampled at edge t: out_valid=1 with idx 0 from t+1 (1-cycle latency).
- With out_ready held high, one coefficient is transferred per cycle. A pass of N entries takes N cycles with no bubbles, including the wrap between passes.
- Final handshake at edge e: out_valid=0, busy=0 and done=1 in cycle e+1. done=0 in e+2.
- A start at e+1 (during DONE) is ignored. The earliest accepted start is in cycle e+2.
- busy=1 exactly while out_valid=1.

## Test plan
- Reset, then start with conj=0 and num_passes=1, out_ready=1, using the 32-entry ROM (NBITS=11):
  - idx0 → re=512, im=0.
  - idx9 → re=502, im=-100.
  - idx31 → re=50, im=-510, out_last=1.
  - done pulses at cycle 33 after start. Exactly 32 transfers occur.
- Same stimulus with conj=1: idx9 → im=+100 and idx31 → im=+510. out_re is unchanged.
- Saturation: slot 31 im=10000000000 (-1024) with conj=1 → idx0 out_im=1023.
- Backpressure: out_ready toggles 1,0,0,1,… → out_* are stable through every stall. The idx sequence is 0..31 with no gaps or duplicates. done follows only the 32nd handshake.
- num_passes=0 → one pass. num_passes=3 → 96 transfers and idx wraps 31→0 without a bubble. out_last pulses 3 times.
- Mid-operation events:
  - abort at idx 10 → out_valid=0 next cycle, no done, and the next start begins at idx0.
  - Async rst at idx 5 → all outputs zero immediately.
  - start during RUN → ignored.
